cpu_controller: RTL
===================

# cpu_controller

Multi-cycle sequencing FSM for the 8-bit processor. It walks each instruction through fetch, decode, execute, data-memory and write-back phases. It drives the enables of the PC, instruction register, ALU/flags, register file and memory bank, and it waits on the data-memory ready handshake. It sits above the write-back stage: the write-back stage steers the data, and this block decides in which cycle each resource acts.

## Interface
Parameters:
- MULDIV_CYCLES, 4, EXECUTE-state dwell for MUL/DIV (legal range 1..15).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  5  opcode field from the instruction register; valid from DECODE onward.
- am  in  1  addressing mode (0 = register operand, 1 = memory operand).
- zero_flag, carry_flag, auxiliary_flag, parity_flag  in  1 each  flag register outputs.
- mem_ready  in  1  data-memory completion for the current request.
- ir_load  out  1  latch the instruction register.
- pc_inc  out  1  increment the PC.
- pc_load  out  1  load the PC from the branch target.
- alu_en  out  1  ALU operates.
- flags_we  out  1  write the flag register.
- reg_we  out  1  register-file write.
- reg_wide  out  1  16-bit register-pair write (MUL/DIV).
- mem_req  out  1  data-memory request.
- mem_rw  out  1  request direction: 1 = read, 0 = write.
- instr_done  out  1  one-cycle retire pulse.
- HALTED  out  1  processor stopped.
- state  out  3  current state, for debug and verification.

## Operation
- States and encodings: FETCH=0, DECODE=1, EXECUTE=2, MEM_RD=3, MEM_WR=4, WRITEBACK=5, HALT=6. Codes 7 and above return to FETCH.
- FETCH:
  - ir_load=1 and pc_inc=1 for exactly one cycle.
  - Next state is DECODE.
- DECODE:
  - opcode and am are latched into op_q and am_q; the latched values hold until the next DECODE.
  - No outputs are asserted.
- Routing out of DECODE, by opcode:
  - MOVE, ADD, SUB, AND, OR, XOR, COMPARE, MUL, DIV: EXECUTE → WRITEBACK.
  - INC, DEC, NOT, ASHL, ASHR, LSHL, LSHR, ROTL, ROTR with am=0: EXECUTE → WRITEBACK.
  - The same unary ops with am=1: MEM_RD → EXECUTE → MEM_WR.
  - LOAD: MEM_RD → WRITEBACK.
  - STORE: EXECUTE → MEM_WR.
  - JUMP, BEQZ, BC, BAUX, BPAR: EXECUTE only.
  - HALT: goes to the HALT state.
  - Undefined opcode: back to FETCH as a NOP, with instr_done pulsed in DECODE.
- EXECUTE:
  - alu_en=1 in every cycle of the dwell.
  - MUL/DIV dwell MULDIV_CYCLES cycles using a down-counter. All other ops dwell 1 cycle.
  - flags_we=1 in the last EXECUTE cycle for ALU ops: everything except MOVE, STORE and the branches.
  - Branches: pc_load=1 when taken. JUMP is always taken. BEQZ/BC/BAUX/BPAR are taken when zero/carry/auxiliary/parity is 1, sampled in the EXECUTE cycle.
  - Branches then go to FETCH with instr_done=1.
- MEM_RD and MEM_WR:
  - mem_req=1, with mem_rw=1 (MEM_RD) or mem_rw=0 (MEM_WR), held until a cycle with mem_ready=1.
  - The state advances on the edge that ends that cycle.
  - MEM_WR completion goes to FETCH with instr_done=1 in the completing cycle.
- WRITEBACK:
  - reg_we=1 and instr_done=1 for one cycle.
  - reg_wide=1 for MUL/DIV.
  - Next state is FETCH.
- HALT:
  - HALTED=1 and all other outputs are 0.
  - The only exit is reset.
- Outputs are combinational decodes of state, op_q, am_q, the counter and the flags. Every output is forced to 0 while reset=1.
- mem_ready is ignored outside the MEM states.

## Timing
- Reset:
  - The state register resets to FETCH, op_q/am_q to 0 and the counter to 0.
  - The first FETCH cycle is the first cycle with reset=0.
  - Reset values of all outputs are 0, with HALTED=0 and state=0.
- Reset in any state takes priority over everything, including a MEM wait or HALT: next state is FETCH and the counter is cleared.
- Latency with mem_ready tied high:
  - Register ALU op: 4 cycles.
  - MUL/DIV: 3+MULDIV_CYCLES cycles.
  - LOAD: 4 cycles.
  - STORE: 4 cycles.
  - Memory-operand unary op: 5 cycles.
  - Branch: 3 cycles.
- Every cycle mem_ready stays low in a MEM state adds one cycle of latency.
- Exactly one of ir_load, alu_en, mem_req, reg_we, HALTED can be active per cycle, apart from the instr_done/pc_load overlaps defined above.
- instr_done fires exactly once per instruction. It never fires for HALT.

## Test plan
- ADD after reset release, cycle 0 = first FETCH:
  - Required: ir_load and pc_inc at c0, alu_en and flags_we at c2, reg_we and instr_done at c3, state=0 at c4.
- MUL with MULDIV_CYCLES=4:
  - Required: alu_en high c2–c5, flags_we only at c5, reg_we and reg_wide at c6, next FETCH at c7.
- INC with am=1, mem_ready low for 3 cycles in MEM_RD, then high:
  - Required: mem_req=1, mem_rw=1 for c2–c5, EXECUTE at c6.
  - Then MEM_WR with mem_ready=1: mem_req=1, mem_rw=0, instr_done at c7, FETCH at c8.
- BEQZ:
  - With zero_flag=0: pc_load=0 at c2.
  - With zero_flag=1: pc_load=1 at c2.
  - JUMP with all flags 0: pc_load=1 at c2.
  - Each case returns to FETCH at c3.
- HALT:
  - Required: HALTED=1 from c2 and no ir_load for the next 20 cycles.
  - Then a 1-cycle reset: HALTED=0 and ir_load=1 in the first cycle after reset.
- Reset asserted for 2 cycles during a STORE's MEM_WR wait (mem_ready=0):
  - Required: mem_req=0 during reset, state=0 afterwards, a normal FETCH follows, and no instr_done for the aborted STORE.

Source files
------------

// File: rtl/cpu_controller.sv
// Multi-cycle sequencing FSM for the 8-bit processor: walks each instruction through
// fetch/decode/execute/memory/write-back and decides in which cycle each resource acts.
module cpu_controller #(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] opcode,
  input  logic       am,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       auxiliary_flag,
  input  logic       parity_flag,
  input  logic       mem_ready,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       alu_en,
  output logic       flags_we,
  output logic       reg_we,
  output logic       reg_wide,
  output logic       mem_req,
  output logic       mem_rw,
  output logic       instr_done,
  output logic       HALTED,
  output logic [2:0] state
);

  // Handshake: mem_req/mem_rw are held in a MEM state until a cycle with mem_ready=1;
  // the transfer completes in that cycle and the state advances on the edge that ends it.

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM_RD    = 3'd3,
    S_MEM_WR    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [4:0] OP_MOVE  = 5'd0;
  localparam logic [4:0] OP_MUL   = 5'd7;
  localparam logic [4:0] OP_DIV   = 5'd8;
  localparam logic [4:0] OP_INC   = 5'd9;
  localparam logic [4:0] OP_ROTR  = 5'd17;
  localparam logic [4:0] OP_LOAD  = 5'd18;
  localparam logic [4:0] OP_STORE = 5'd19;
  localparam logic [4:0] OP_JUMP  = 5'd20;
  localparam logic [4:0] OP_BEQZ  = 5'd21;
  localparam logic [4:0] OP_BC    = 5'd22;
  localparam logic [4:0] OP_BAUX  = 5'd23;
  localparam logic [4:0] OP_BPAR  = 5'd24;
  localparam logic [4:0] OP_HALT  = 5'd25;

  localparam logic [3:0] MD_LAST = 4'(MULDIV_CYCLES - 1);

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_unary(input logic [4:0] op);
    return (op >= OP_INC) && (op <= OP_ROTR);
  endfunction

  function automatic logic is_branch(input logic [4:0] op);
    return (op >= OP_JUMP) && (op <= OP_BPAR);
  endfunction

  state_t     state_q, state_d;
  logic [4:0] op_q, op_d;
  logic       am_q, am_d;
  logic [3:0] cnt_q, cnt_d;

  logic ir_load_c, pc_inc_c, pc_load_c, alu_en_c, flags_we_c, reg_we_c;
  logic reg_wide_c, mem_req_c, mem_rw_c, instr_done_c, halted_c;
  logic taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= 5'd0;
      am_q    <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      am_q    <= am_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    taken = 1'b0;
    case (op_q)
      OP_JUMP: taken = 1'b1;
      OP_BEQZ: taken = zero_flag;
      OP_BC:   taken = carry_flag;
      OP_BAUX: taken = auxiliary_flag;
      OP_BPAR: taken = parity_flag;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    am_d         = am_q;
    cnt_d        = cnt_q;
    ir_load_c    = 1'b0;
    pc_inc_c     = 1'b0;
    pc_load_c    = 1'b0;
    alu_en_c     = 1'b0;
    flags_we_c   = 1'b0;
    reg_we_c     = 1'b0;
    reg_wide_c   = 1'b0;
    mem_req_c    = 1'b0;
    mem_rw_c     = 1'b0;
    instr_done_c = 1'b0;
    halted_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_load_c = 1'b1;
        pc_inc_c  = 1'b1;
        state_d   = S_DECODE;
      end

      S_DECODE: begin
        // Routing uses the live opcode because op_q only takes it on this edge.
        op_d  = opcode;
        am_d  = am;
        cnt_d = is_muldiv(opcode) ? MD_LAST : 4'd0;
        if (opcode <= OP_DIV || is_branch(opcode) || opcode == OP_STORE) begin
          state_d = S_EXECUTE;
        end else if (is_unary(opcode)) begin
          state_d = am ? S_MEM_RD : S_EXECUTE;
        end else if (opcode == OP_LOAD) begin
          state_d = S_MEM_RD;
        end else if (opcode == OP_HALT) begin
          state_d = S_HALT;
        end else begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_EXECUTE: begin
        alu_en_c = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          flags_we_c = (op_q != OP_MOVE) && (op_q != OP_STORE) && !is_branch(op_q);
          if (is_branch(op_q)) begin
            pc_load_c    = taken;
            instr_done_c = 1'b1;
            state_d      = S_FETCH;
          end else if (op_q == OP_STORE || (is_unary(op_q) && am_q)) begin
            state_d = S_MEM_WR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end

      S_MEM_RD: begin
        mem_req_c = 1'b1;
        mem_rw_c  = 1'b1;
        if (mem_ready) begin
          state_d = (op_q == OP_LOAD) ? S_WRITEBACK : S_EXECUTE;
        end
      end

      S_MEM_WR: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          instr_done_c = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_WRITEBACK: begin
        reg_we_c     = 1'b1;
        reg_wide_c   = is_muldiv(op_q);
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_HALT: begin
        halted_c = 1'b1;
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ir_load    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    alu_en     = 1'b0;
    flags_we   = 1'b0;
    reg_we     = 1'b0;
    reg_wide   = 1'b0;
    mem_req    = 1'b0;
    mem_rw     = 1'b0;
    instr_done = 1'b0;
    HALTED     = 1'b0;
    state      = 3'd0;
    if (!reset) begin
      ir_load    = ir_load_c;
      pc_inc     = pc_inc_c;
      pc_load    = pc_load_c;
      alu_en     = alu_en_c;
      flags_we   = flags_we_c;
      reg_we     = reg_we_c;
      reg_wide   = reg_wide_c;
      mem_req    = mem_req_c;
      mem_rw     = mem_rw_c;
      instr_done = instr_done_c;
      HALTED     = halted_c;
      state      = state_q;
    end
  end

endmodule
